// File: rtl/time_alarm.sv
// Time-of-day counter (HH:MM:SS) with per-field set, settable alarm,
// auto-timeout ring and snooze countdown.
module time_alarm #(
  parameter int unsigned DIV        = 50_000_000,
  parameter int unsigned HMAX       = 23,
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       plus,
  input  logic       minus,
  input  logic [2:0] mode,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic [5:0] hours,
  output logic [5:0] mins,
  output logic [5:0] secs,
  output logic [5:0] al_hours,
  output logic [5:0] al_mins,
  output logic       ringing,
  output logic       snoozing
);

  localparam int unsigned DivW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RingW    = $clog2(RING_SECS + 1);
  localparam int unsigned SnzTicks = SNOOZE_MIN * 60;
  localparam int unsigned SnzW     = $clog2(SnzTicks + 1);
  localparam logic [5:0]  HMax     = 6'(HMAX);
  localparam logic [5:0]  SecMax   = 6'd59;

  logic [DivW-1:0]  div_q, div_d;
  logic [5:0]       hours_q, hours_d, mins_q, mins_d, secs_q, secs_d;
  logic [5:0]       al_hours_q, al_hours_d, al_mins_q, al_mins_d;
  logic             ringing_q, ringing_d, snoozing_q, snoozing_d;
  logic [RingW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SnzW-1:0]  snz_cnt_q, snz_cnt_d;

  logic       set_time, tick, trigger, snz_expire;
  logic       sec_wrap, min_wrap;
  logic [5:0] t_secs, t_mins, t_hours;

  // Wrapping single-step edit; plus and minus together cancel.
  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] max,
                                            input logic up, input logic dn);
    logic [5:0] r;
    r = v;
    if (up && !dn) r = (v == max) ? 6'd0 : v + 6'd1;
    if (dn && !up) r = (v == 6'd0) ? max : v - 6'd1;
    return r;
  endfunction

  always_comb begin
    set_time = mode inside {3'b001, 3'b010, 3'b011};
    tick     = enable & ~set_time & (div_q == DivW'(DIV - 1));

    sec_wrap = (secs_q == SecMax);
    min_wrap = (mins_q == SecMax);
    t_secs   = sec_wrap ? 6'd0 : secs_q + 6'd1;
    t_mins   = sec_wrap ? (min_wrap ? 6'd0 : mins_q + 6'd1) : mins_q;
    t_hours  = (sec_wrap && min_wrap) ? ((hours_q == HMax) ? 6'd0 : hours_q + 6'd1) : hours_q;

    // Only a counting tick can trigger, so manual edits into the match never ring.
    trigger    = tick & alarm_en & (t_secs == 6'd0) & (t_mins == al_mins_q) &
                 (t_hours == al_hours_q);
    snz_expire = snoozing_q & tick & (snz_cnt_q == SnzW'(1));
  end

  always_comb begin
    div_d      = div_q;
    hours_d    = hours_q;
    mins_d     = mins_q;
    secs_d     = secs_q;
    al_hours_d = al_hours_q;
    al_mins_d  = al_mins_q;
    ringing_d  = ringing_q;
    snoozing_d = snoozing_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;

    if (set_time) begin
      div_d = '0;
    end else if (enable) begin
      div_d = tick ? '0 : div_q + DivW'(1);
    end

    if (tick) begin
      secs_d  = t_secs;
      mins_d  = t_mins;
      hours_d = t_hours;
    end

    case (mode)
      3'b001:  secs_d     = step_field(secs_q, SecMax, plus, minus);
      3'b010:  mins_d     = step_field(mins_q, SecMax, plus, minus);
      3'b011:  hours_d    = step_field(hours_q, HMax, plus, minus);
      3'b100:  al_mins_d  = step_field(al_mins_q, SecMax, plus, minus);
      3'b101:  al_hours_d = step_field(al_hours_q, HMax, plus, minus);
      default: ;
    endcase

    if (stop || !alarm_en) begin
      ringing_d  = 1'b0;
      snoozing_d = 1'b0;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else if (trigger) begin
      ringing_d  = 1'b1;
      snoozing_d = 1'b0;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else if (snz_expire) begin
      ringing_d  = 1'b1;
      snoozing_d = 1'b0;
      ring_cnt_d = '0;
      snz_cnt_d  = '0;
    end else if (snooze && ringing_q) begin
      ringing_d  = 1'b0;
      snoozing_d = 1'b1;
      snz_cnt_d  = SnzW'(SnzTicks);
    end else begin
      if (snoozing_q && tick) snz_cnt_d = snz_cnt_q - SnzW'(1);
      // Ringing lasts exactly RING_SECS ticks counted from the trigger edge.
      if (ringing_q && tick) begin
        if (ring_cnt_q == RingW'(RING_SECS - 1)) begin
          ringing_d  = 1'b0;
          ring_cnt_d = '0;
        end else begin
          ring_cnt_d = ring_cnt_q + RingW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      hours_q    <= '0;
      mins_q     <= '0;
      secs_q     <= '0;
      al_hours_q <= '0;
      al_mins_q  <= '0;
      ringing_q  <= 1'b0;
      snoozing_q <= 1'b0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
    end else begin
      div_q      <= div_d;
      hours_q    <= hours_d;
      mins_q     <= mins_d;
      secs_q     <= secs_d;
      al_hours_q <= al_hours_d;
      al_mins_q  <= al_mins_d;
      ringing_q  <= ringing_d;
      snoozing_q <= snoozing_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end

  assign hours    = hours_q;
  assign mins     = mins_q;
  assign secs     = secs_q;
  assign al_hours = al_hours_q;
  assign al_mins  = al_mins_q;
  assign ringing  = ringing_q;
  assign snoozing = snoozing_q;

endmodule

// File: tb/tb_time_alarm.sv
// Directed bench for time_alarm: expected states queued with the stimulus,
// popped and compared when the DUT state is sampled.
module tb_time_alarm;

  logic       clk = 1'b0;
  logic       reset, enable, plus, minus, alarm_en, stop, snooze;
  logic [2:0] mode;
  logic [5:0] hours, mins, secs, al_hours, al_mins;
  logic       ringing, snoozing;
  logic [31:0] obs;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int checks   = 0;
  int failures = 0;

  time_alarm #(
    .DIV       (4),
    .HMAX      (23),
    .RING_SECS (3),
    .SNOOZE_MIN(1)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .plus    (plus),
    .minus   (minus),
    .mode    (mode),
    .alarm_en(alarm_en),
    .stop    (stop),
    .snooze  (snooze),
    .hours   (hours),
    .mins    (mins),
    .secs    (secs),
    .al_hours(al_hours),
    .al_mins (al_mins),
    .ringing (ringing),
    .snoozing(snoozing)
  );

  always #5 clk = ~clk;

  assign obs = {hours, mins, secs, al_hours, al_mins, ringing, snoozing};

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic compare_front();
    sb_item_t it;
    it = sb.pop_front();
    checks++;
    assert (obs === it.exp)
    else begin
      failures++;
      $error("FAIL %s observed hh:mm:ss/al/r/s=%0d:%0d:%0d/%0d:%0d/%0d/%0d expected=%0d:%0d:%0d/%0d:%0d/%0d/%0d",
             it.tag, obs[31:26], obs[25:20], obs[19:14], obs[13:8], obs[7:2], obs[1], obs[0],
             it.exp[31:26], it.exp[25:20], it.exp[19:14], it.exp[13:8], it.exp[7:2],
             it.exp[1], it.exp[0]);
    end
  endtask

  // Queue the expected state, advance n cycles, then compare.
  task automatic expect_state(input string tag, input int n, input logic [5:0] h, m, s, ah,
                              am, input logic r, sn);
    sb_item_t it;
    it.tag = tag;
    it.exp = {h, m, s, ah, am, r, sn};
    sb.push_back(it);
    if (n > 0) cycles(n);
    compare_front();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; enable = 1'b0; plus = 1'b0; minus = 1'b0; mode = 3'b000;
    alarm_en = 1'b0; stop = 1'b0; snooze = 1'b0;
    #12;
    expect_state("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    cycles(1);
    reset = 1'b0; enable = 1'b1;

    // Basic counting and pause
    expect_state("sec1", 4, 0, 0, 1, 0, 0, 0, 0);
    expect_state("sec59", 232, 0, 0, 59, 0, 0, 0, 0);
    expect_state("min1", 4, 0, 1, 0, 0, 0, 0, 0);
    enable = 1'b0;
    expect_state("frozen", 10, 0, 1, 0, 0, 0, 0, 0);

    // Preset 23:59:58 and wrap the day
    mode = 3'b011; minus = 1'b1; cycles(1);
    mode = 3'b010; cycles(2);
    mode = 3'b001; cycles(2);
    minus = 1'b0; mode = 3'b000;
    expect_state("preset", 0, 23, 59, 58, 0, 0, 0, 0);
    enable = 1'b1;
    expect_state("pre_wrap", 4, 23, 59, 59, 0, 0, 0, 0);
    expect_state("hour_wrap", 4, 0, 0, 0, 0, 0, 0, 0);

    // Field edits
    mode = 3'b001; minus = 1'b1;
    expect_state("sec_dec_wrap", 1, 0, 0, 59, 0, 0, 0, 0);
    plus = 1'b1;
    expect_state("plus_minus", 1, 0, 0, 59, 0, 0, 0, 0);
    plus = 1'b0; mode = 3'b011;
    expect_state("hour_dec_wrap", 1, 23, 0, 59, 0, 0, 0, 0);
    minus = 1'b0; plus = 1'b1;
    expect_state("hour_inc_wrap", 1, 0, 0, 59, 0, 0, 0, 0);
    plus = 1'b0;

    // Alarm at 00:01, ring for three ticks
    enable = 1'b0; mode = 3'b100; plus = 1'b1;
    expect_state("al_set", 1, 0, 0, 59, 0, 1, 0, 0);
    plus = 1'b0; mode = 3'b000; alarm_en = 1'b1; enable = 1'b1;
    expect_state("pre_alarm", 3, 0, 0, 59, 0, 1, 0, 0);
    expect_state("alarm_ring", 1, 0, 1, 0, 0, 1, 1, 0);
    expect_state("ring2", 8, 0, 1, 2, 0, 1, 1, 0);
    expect_state("ring_off", 4, 0, 1, 3, 0, 1, 0, 0);

    // Snooze cycle with alarm at 00:02
    enable = 1'b0; mode = 3'b001; minus = 1'b1; cycles(4);
    minus = 1'b0; mode = 3'b100; plus = 1'b1; cycles(1);
    plus = 1'b0; mode = 3'b000; enable = 1'b1;
    expect_state("snz_ring", 4, 0, 2, 0, 0, 2, 1, 0);
    snooze = 1'b1;
    expect_state("snoozed", 1, 0, 2, 0, 0, 2, 0, 1);
    snooze = 1'b0;
    expect_state("snz_wait", 238, 0, 2, 59, 0, 2, 0, 1);
    expect_state("snz_expire", 1, 0, 3, 0, 0, 2, 1, 0);
    stop = 1'b1;
    expect_state("stop", 1, 0, 3, 0, 0, 2, 0, 0);
    stop = 1'b0; snooze = 1'b1;
    expect_state("snz_idle", 1, 0, 3, 0, 0, 2, 0, 0);
    snooze = 1'b0;

    // Manual set into the alarm time must not ring
    mode = 3'b010; minus = 1'b1;
    expect_state("set_match", 1, 0, 2, 0, 0, 2, 0, 0);
    cycles(1);
    mode = 3'b001; cycles(1);
    minus = 1'b0; mode = 3'b000;
    expect_state("ring_again", 4, 0, 2, 0, 0, 2, 1, 0);

    // Asynchronous reset while ringing
    #2; reset = 1'b1; #1;
    expect_state("reset_async", 0, 0, 0, 0, 0, 0, 0, 0);
    cycles(1);
    reset = 1'b0;
    expect_state("no_tick_release", 3, 0, 0, 0, 0, 0, 0, 0);
    expect_state("tick_after", 1, 0, 0, 1, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_alarm.md
# time_alarm

Parametrised time-of-day counter with a settable alarm, auto-timeout ring and snooze. It divides the system clock to a 1 s tick and keeps HH:MM:SS with per-field set via plus/minus. It compares the running time against a separately settable alarm time. It sits between the board clock and the 7-segment/LED display logic, replacing the plain clock counter in the watch top level.

## Interface
Parameters:
- DIV, 50_000_000, clk cycles per 1 s tick (≥2)
- HMAX, 23, maximum hour value; hours wrap HMAX→0
- RING_SECS, 60, ticks the alarm rings before auto-stop (≥1)
- SNOOZE_MIN, 5, snooze length in minutes (≥1); countdown = SNOOZE_MIN*60 ticks

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- enable  in  1  run/pause of time keeping
- plus  in  1  increment selected field, one step per asserted cycle
- minus  in  1  decrement selected field, one step per asserted cycle
- mode  in  3  000 run, 001 set secs, 010 set mins, 011 set hours, 100 set alarm mins, 101 set alarm hours; 110/111 behave as 000
- alarm_en  in  1  arm alarm; low clears ringing and snooze
- stop  in  1  pulse: cancel ringing and pending snooze
- snooze  in  1  pulse: while ringing, silence and restart after snooze period
- hours, mins, secs  out  6 each  current time
- al_hours, al_mins  out  6 each  alarm time
- ringing  out  1  alarm active
- snoozing  out  1  snooze countdown pending

## Operation
- Reset values: hours/mins/secs/al_hours/al_mins = 0, ringing = 0, snoozing = 0, divider = 0, ring and snooze counters = 0.
- Divider: counts 0..DIV-1 when enable=1 and mode ∉ {001,010,011}; holds when enable=0; forced to 0 while mode ∈ {001,010,011}. tick = (divider==DIV-1) & counting.
- On tick: secs+1; secs 59→0 carries to mins; mins 59→0 carries to hours; hours HMAX→0.
- Set modes (001..101): plus → field+1 wrapping at max→0; minus → field−1 wrapping 0→max; plus&minus same cycle → no change. No carry into other fields. Time counting frozen in 001..011; runs normally in 100/101.
- Alarm trigger: on a tick whose next time equals al_hours:al_mins:00 and alarm_en=1 → ringing=1, ring counter=0, snoozing=0. Manual setting into the match never triggers.
- Ringing: ring counter increments per tick; ringing clears on the tick where counter reaches RING_SECS-1 (exactly RING_SECS ticks). No snooze on auto-stop.
- Snooze: snooze pulse while ringing → ringing=0, snoozing=1, countdown loaded SNOOZE_MIN*60. Countdown decrements per tick; on the tick reaching 0 → snoozing=0, ringing=1, ring counter=0. Snooze while not ringing ignored.
- stop pulse or alarm_en=0 → ringing=0, snoozing=0 next edge.

## Timing
- All outputs registered; changes appear on the edge after the causing cycle.
- secs updates on the edge ending the tick cycle; mins/hours carry on the same edge.
- ringing asserts on the same edge that time becomes HH:MM:00.
- plus/minus: one step per asserted cycle; a held input steps every cycle.
- Priority per cycle: reset > stop/alarm_en=0 > alarm trigger > snooze expiry > snooze pulse > ring timeout.
- Alarm trigger while snoozing: ringing=1, snoozing=0.
- Set-mode edits while ringing leave ringing/snoozing unchanged.
- Mode change 000→001: divider 0 next edge; on return to 000 first tick after DIV cycles.
- reset asserted mid-count: all outputs 0 immediately (asynchronous), no tick on release edge.

## Test plan
Parameters DIV=4, RING_SECS=3, SNOOZE_MIN=1.
- Reset, enable=1, run 4*60 cycles → secs 0→59→0, mins=1 at cycle 240; enable=0 for 10 cycles → time frozen.
- Preset 23:59:58, run 8 cycles → 00:00:00, hours wrap at HMAX.
- mode=001, minus one cycle from secs=0 → secs=59, mins unchanged; plus&minus together → no change; mode=011 plus from 23 → 0.
- Alarm 00:01, alarm_en=1, time 00:00:59 → ringing=1 on edge time becomes 00:01:00; deasserts after 3 ticks (00:01:03).
- Ringing, snooze pulse → ringing=0, snoozing=1; after 60 ticks → ringing=1, snoozing=0; stop pulse → both 0.
- Set time to alarm value via mode 010 → ringing stays 0; reset during ringing → all outputs 0 immediately.
